// File: rtl/nios2_mult_pipe_if.sv
// Operand/result handshake bundle for nios2_mult_pipe.
// Tag signals exist only when NIOS2_MULT_PIPE_TAG_EN is defined.
interface nios2_mult_pipe_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
`ifdef NIOS2_MULT_PIPE_TAG_EN
  logic [TAG_W-1:0]  in_tag;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
`else
  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result
  );
`endif
endinterface

// File: rtl/nios2_mult_pipe.sv
// Three-stage sliced multiplier (products, sum+sign fix, half select).
// Optional sideband tag path: define NIOS2_MULT_PIPE_TAG_EN.
module nios2_mult_pipe #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16,
  parameter int TAG_W   = 5
) (
  input logic clk,
  input logic reset,
  nios2_mult_pipe_if.slave bus
);

  localparam int NS = DATA_W / SLICE_W;
  localparam int NP = NS * NS;
  localparam int PW = 2 * SLICE_W;
  localparam int WW = 2 * DATA_W;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_XUU = 2'b01;
  localparam logic [1:0] OP_XSU = 2'b10;
  localparam logic [1:0] OP_XSS = 2'b11;

  logic              adv;
  logic              v1, v2, v3;

  logic [PW-1:0]     pp [NP];
  logic [PW-1:0]     p1 [NP];
  logic [1:0]        op1;
  logic [DATA_W-1:0] a1;
  logic [DATA_W-1:0] b1;

  logic              a_sgn;
  logic              b_sgn;
  logic [WW-1:0]     acc;
  logic [WW-1:0]     s2;
  logic [1:0]        op2;

  logic [DATA_W-1:0] res3;

  // Whole pipe moves as one; a stalled output freezes every stage.
  assign adv          = ~v3 | bus.out_ready;
  assign bus.in_ready = adv | reset;
  assign bus.out_valid  = v3;
  assign bus.out_result = res3;

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      pp[i] = '0;
    end
    for (int i = 0; i < NS; i++) begin
      for (int j = 0; j < NS; j++) begin
        pp[i*NS+j] = PW'(bus.in_a[i*SLICE_W +: SLICE_W])
                   * PW'(bus.in_b[j*SLICE_W +: SLICE_W]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      p1  <= pp;
      op1 <= bus.in_op;
      a1  <= bus.in_a;
      b1  <= bus.in_b;
    end
  end

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (1'b1)
      (op1 == OP_XSS): begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      (op1 == OP_XSU): a_sgn = 1'b1;
      (op1 == OP_XUU): ;
      (op1 == OP_MUL): ;
      default: ;
    endcase
  end

  // Signed product = unsigned product minus the msb-weighted other operand.
  always_comb begin
    acc = '0;
    for (int i = 0; i < NS; i++) begin
      for (int j = 0; j < NS; j++) begin
        acc = acc + (WW'(p1[i*NS+j]) << ((i + j) * SLICE_W));
      end
    end
    if (a_sgn && a1[DATA_W-1]) begin
      acc = acc - {b1, {DATA_W{1'b0}}};
    end
    if (b_sgn && b1[DATA_W-1]) begin
      acc = acc - {a1, {DATA_W{1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s2  <= acc;
      op2 <= op1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      res3 <= '0;
    end else if (adv) begin
      v1   <= bus.in_valid;
      v2   <= v1;
      v3   <= v2;
      res3 <= (op2 == OP_MUL) ? s2[DATA_W-1:0] : s2[WW-1:DATA_W];
    end
  end

`ifdef NIOS2_MULT_PIPE_TAG_EN
  logic [TAG_W-1:0] t1, t2, t3;

  assign bus.out_tag = t3;

  always_ff @(posedge clk) begin
    if (reset) begin
      t1 <= '0;
      t2 <= '0;
      t3 <= '0;
    end else if (adv) begin
      t1 <= bus.in_tag;
      t2 <= t1;
      t3 <= t2;
    end
  end
`endif

endmodule
